divider: RTL

//  Multi-cycle integer divide unit for RV32M DIV/DIVU/REM/REMU; inverse of the multiply path.

---
 rtl/divider.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/divider.sv
// Radix-2 restoring integer divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; valid/ready handshake on request and result.
module divider #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_A,
    input  logic [XLEN-1:0] i_B,
    input  logic            i_kill,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_out
);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   out_q, out_d;
    logic              rem_op_q, rem_op_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;

    logic              accept;
    logic              sign_a, sign_b;
    logic              ovf_case;
    logic [XLEN:0]     shifted;
    logic              ge;
    logic [XLEN-1:0]   diff;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    assign accept   = i_valid && ready_q && !i_kill;
    assign sign_a   = !i_op[0] && i_A[XLEN-1];
    assign sign_b   = !i_op[0] && i_B[XLEN-1];
    assign ovf_case = !i_op[0] && (i_A == {1'b1, {(XLEN-1){1'b0}}}) && (i_B == {XLEN{1'b1}});

    // Partial remainder stays below the divisor, so the XLEN-bit difference is exact when ge.
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign ge      = shifted >= {1'b0, dvs_q};
    assign diff    = shifted[XLEN-1:0] - dvs_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        valid_d   = valid_q;
        out_d     = out_q;
        rem_op_d  = rem_op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    rem_op_d  = i_op[1];
                    neg_quo_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    ready_d   = 1'b0;
                    if (i_B == '0) begin
                        out_d   = i_op[1] ? i_A : {XLEN{1'b1}};
                        valid_d = 1'b1;
                        state_d = DONE;
                    end else if (ovf_case) begin
                        out_d   = i_op[1] ? '0 : i_A;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d   = CNT_W'(XLEN - 1);
                        rem_d   = '0;
                        quo_d   = cond_neg(i_A, sign_a);
                        dvs_d   = cond_neg(i_B, sign_b);
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d = ge ? diff : shifted[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], ge};
                cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                out_d   = rem_op_q ? cond_neg(rem_q, neg_rem_q) : cond_neg(quo_q, neg_quo_q);
                valid_d = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                valid_d = 1'b0;
            end
        endcase

        // A flush wins over everything, including a pending result handshake.
        if (i_kill) begin
            state_d = IDLE;
            ready_d = 1'b1;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            out_q   <= out_d;
        end
        rem_op_q  <= rem_op_d;
        neg_quo_q <= neg_quo_d;
        neg_rem_q <= neg_rem_d;
        rem_q     <= rem_d;
        quo_q     <= quo_d;
        dvs_q     <= dvs_d;
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_out   = out_q;

endmodule
